// File: rtl/fifo_arb_pkg.sv
// Shared types and default constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_BURST = 4;

    // Width of each per-requester accepted-beat counter.
    localparam int STATS_W = 16;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin priority search: first asserted request after last_grant,
// wrapping NREQ-1 -> 0. Purely combinational.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
)(
    input  logic [NREQ-1:0]         req_valid,
    input  logic [$clog2(NREQ)-1:0] last_grant,
    output logic                    found,
    output logic [$clog2(NREQ)-1:0] index
);

    localparam int IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0] cand;

    // Walk the offsets from farthest to nearest so the nearest hit is the last one kept.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_grant) + k) % NREQ);
            if (req_valid[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter in front of the FIFO write port.
// A grant lasts up to MAX_BURST beats or until the owner drops valid; each
// grant change costs one IDLE cycle. Accepted beats reach the FIFO one cycle
// later through registered write_en/data. fifo_afull stalls without revoking.
// Optional per-requester beat counters: define FIFO_WRITE_ARB_STATS_EN.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    fifo_afull,
    output logic                    fifo_write_en,
    output logic [WIDTH-1:0]        fifo_data,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy
`ifdef FIFO_WRITE_ARB_STATS_EN
    ,
    input  logic                    stats_clr,
    output logic [NREQ*STATS_W-1:0] beat_count
`endif
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             wen_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] sel_data;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             granted_valid;
    logic             accept;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_valid  (req_valid),
        .last_grant (last_q),
        .found      (pick_found),
        .index      (pick_idx)
    );

    assign granted_valid = req_valid[grant_q];
    assign accept        = (state_q == BURST) && !fifo_afull && granted_valid;

    // Only the granted requester sees ready, and only while the FIFO has room.
    always_comb begin
        req_ready = '0;
        if (state_q == BURST && !fifo_afull) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    // Data mux for the granted requester.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state: arbitrate in IDLE, count beats and release in BURST.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (!granted_valid) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM registers; reset points priority at requester 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_q     <= IDX_W'(NREQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Output register toward the FIFO; a reset discards the beat in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q  <= 1'b0;
            data_q <= '0;
        end else begin
            wen_q <= accept;
            if (accept) begin
                data_q <= sel_data;
            end
        end
    end

    assign fifo_write_en = wen_q;
    assign fifo_data     = data_q;
    assign grant_id      = grant_q;
    assign busy          = (state_q == BURST);

`ifdef FIFO_WRITE_ARB_STATS_EN
    logic [STATS_W-1:0] stat_q [NREQ];

    // Saturating accepted-beat counters; clear wins over increment.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rst || stats_clr) begin
                stat_q[i] <= '0;
            end else if (accept && grant_q == IDX_W'(i) && stat_q[i] != '1) begin
                stat_q[i] <= stat_q[i] + STATS_W'(1);
            end
        end
    end

    // Flatten the counters onto the output bus.
    always_comb begin
        beat_count = '0;
        for (int i = 0; i < NREQ; i++) begin
            beat_count[i*STATS_W +: STATS_W] = stat_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with a write-data scoreboard.
module tb_fifo_write_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_afull;
    logic                  fifo_write_en;
    logic [WIDTH-1:0]      fifo_data;
    logic [1:0]            grant_id;
    logic                  busy;
`ifdef FIFO_WRITE_ARB_STATS_EN
    logic                  stats_clr = 1'b0;
    logic [NREQ*16-1:0]    beat_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int         wq[$];
    int         gq[$];
    logic [7:0] src_data[NREQ];
    int         src_left[NREQ];
    logic [NREQ-1:0] hs_q;
    logic       prev_acc;
    logic       busy_prev;
    logic       mon_en;
    int         cyc;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fifo_afull    (fifo_afull),
        .fifo_write_en (fifo_write_en),
        .fifo_data     (fifo_data),
        .grant_id      (grant_id),
        .busy          (busy)
`ifdef FIFO_WRITE_ARB_STATS_EN
        ,
        .stats_clr     (stats_clr),
        .beat_count    (beat_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (src_left[i] > 0);
            req_data[i*WIDTH +: WIDTH] = src_data[i];
        end
    endtask

    // One clock: producers advance on handshakes seen before the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs_q[i]) begin
                src_data[i] = src_data[i] + 8'd1;
                src_left[i] = src_left[i] - 1;
            end
        end
        drive();
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    function automatic bit any_src();
        bit r = 1'b0;
        for (int i = 0; i < NREQ; i++) if (src_left[i] > 0) r = 1'b1;
        return r;
    endfunction

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || any_src()) && n < budget) begin
            cycle();
            sample();
            n++;
        end
        chk("drain_budget", n < budget, 1);
        repeat (3) begin
            cycle();
            sample();
        end
        chk("queue_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    // Scoreboard monitor: write timing, write data, ready exclusivity, grant log.
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            chk("wen_latency", fifo_write_en, prev_acc);
            if (fifo_write_en === 1'b1) begin
                wq.push_back(cyc);
                chk("write_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("fifo_data", fifo_data, exp_q.pop_front());
            end
            chk("ready_onehot", $countones(req_ready) <= 1, 1);
            if (busy === 1'b1 && busy_prev !== 1'b1) gq.push_back(int'(grant_id));
        end
        hs_q      = rst ? '0 : (req_valid & req_ready);
        prev_acc  = |hs_q;
        busy_prev = busy;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int g;
        rst = 1'b1; fifo_afull = 1'b0; mon_en = 1'b0; prev_acc = 1'b0;
        busy_prev = 1'b0; cyc = 0; hs_q = '0;
        for (int i = 0; i < NREQ; i++) begin
            src_left[i] = 0;
            src_data[i] = 8'h00;
        end
        drive();

        // Reset values, then 10 quiet cycles.
        repeat (2) cycle();
        sample();
        chk("rst_busy", busy, 0);
        chk("rst_wen", fifo_write_en, 0);
        chk("rst_data", fifo_data, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_ready", req_ready, 0);
        cycle();
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (10) begin
            sample();
            chk("idle_busy", busy, 0);
            chk("idle_wen", fifo_write_en, 0);
            chk("idle_ready", req_ready, 0);
            chk("idle_grant", grant_id, 0);
            cycle();
        end

        // Requester 2 alone: two bursts of 4 with a one-cycle gap.
        src_data[2] = 8'h10; src_left[2] = 8; drive();
        for (int b = 0; b < 8; b++) exp_q.push_back(8'(8'h10 + b));
        wq.delete();
        wait_drain(60);
        chk("t2_writes", wq.size(), 8);
        g = (wq.size() >= 5) ? wq[3] - wq[0] : -1;
        chk("t2_burst_back2back", g, 3);
        g = (wq.size() >= 5) ? wq[4] - wq[3] : -1;
        chk("t2_gap", g, 2);

        // All four requesters continuously valid.
        do_reset();
        gq.delete();
        for (int r = 0; r < NREQ; r++) begin
            src_data[r] = 8'(r * 32);
            src_left[r] = 8;
        end
        drive();
        for (int rnd = 0; rnd < 2; rnd++)
            for (int r = 0; r < NREQ; r++)
                for (int b = 0; b < 4; b++)
                    exp_q.push_back(8'(r * 32 + rnd * 4 + b));
        wait_drain(150);
        for (int k = 0; k < 5; k++) begin
            g = (gq.size() > k) ? gq[k] : -1;
            chk("t3_grant_order", g, k % NREQ);
        end

        // Requester 1 stalled by afull after its second beat.
        cycle();
        src_data[1] = 8'h50; src_left[1] = 4; drive();
        for (int b = 0; b < 4; b++) exp_q.push_back(8'(8'h50 + b));
        n = 0;
        while (n < 20) begin
            cycle();
            n++;
            if (src_left[1] <= 2) break;
        end
        chk("t4_two_beats", src_left[1], 2);
        fifo_afull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sample();
            chk("t4_ready", req_ready, 0);
            chk("t4_grant", grant_id, 1);
            chk("t4_busy", busy, 1);
            chk("t4_wen", fifo_write_en, k == 0);
            cycle();
        end
        fifo_afull = 1'b0;
        wait_drain(30);
        chk("t4_all_beats", src_left[1], 0);

        // Requester 0 releases after one beat; requester 1 wins next.
        cycle();
        gq.delete();
        src_data[0] = 8'hA0; src_left[0] = 1;
        src_data[1] = 8'hB0; src_left[1] = 2;
        drive();
        exp_q.push_back(8'hA0); exp_q.push_back(8'hB0); exp_q.push_back(8'hB1);
        n = 0;
        while (src_left[0] > 0 && n < 20) begin
            cycle();
            n++;
        end
        sample();
        chk("t5_still_burst", busy, 1);
        cycle();
        sample();
        chk("t5_exit_idle", busy, 0);
        wait_drain(30);
        g = (gq.size() >= 2) ? gq[0] : -1;
        chk("t5_first_grant", g, 0);
        g = (gq.size() >= 2) ? gq[1] : -1;
        chk("t5_second_grant", g, 1);

        // Reset mid-burst on requester 3 right after an accept.
        cycle();
        gq.delete();
        src_data[3] = 8'hC0; src_left[3] = 4; drive();
        exp_q.push_back(8'hC0);
        n = 0;
        while (n < 20) begin
            cycle();
            n++;
            if (src_left[3] <= 3) break;
        end
        chk("t6_one_beat", src_left[3], 3);
        rst = 1'b1;
        sample();
        chk("t6_ready_before_rst", req_ready, 4'b1000);
        cycle();
        rst = 1'b0;
        src_data[0] = 8'hD0; src_left[0] = 1; drive();
        sample();
        chk("t6_wen_dropped", fifo_write_en, 0);
        chk("t6_busy", busy, 0);
        chk("t6_grant", grant_id, 0);
        exp_q.push_back(8'hD0);
        exp_q.push_back(8'hC1); exp_q.push_back(8'hC2); exp_q.push_back(8'hC3);
        wait_drain(60);
        g = (gq.size() >= 3) ? gq[1] : -1;
        chk("t6_grant_after_rst", g, 0);
        g = (gq.size() >= 3) ? gq[2] : -1;
        chk("t6_grant_then_3", g, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
